// File: rtl/present_key_schedule.sv
// rtl/present_key_schedule.sv - PRESENT-80 round-key generator streaming K1..K32 over a valid/ready handshake
module present_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [79:0] key,
    input  logic        rk_ready,
    output logic        busy,
    output logic        rk_valid,
    output logic [4:0]  rk_index,
    output logic [63:0] round_key,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        LAST = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [79:0] k;
    logic [79:0] k_next;
    logic [4:0]  rc;
    logic [4:0]  rc_next;
    logic        load;
    logic        xfer;
    logic        busy_next;
    logic        done_next;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // One schedule step: rotate left by 61, S-box on the top nibble, mix in the round counter.
    function automatic logic [79:0] key_update(input logic [79:0] cur, input logic [4:0] i);
        logic [79:0] r;
        r        = {cur[18:0], cur[79:19]};
        r[79:76] = sbox(r[79:76]);
        r[19:15] = r[19:15] ^ i;
        return r;
    endfunction

    assign load = (state == IDLE) && start;
    assign xfer = rk_valid && rk_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = EMIT;
            EMIT: if (xfer && (rc == 5'd31)) state_next = LAST;
            LAST: if (xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_next = (state_next != IDLE);
        done_next = (state_next == LAST);
    end

    always_comb begin
        k_next  = k;
        rc_next = rc;
        if (load) begin
            k_next  = key;
            rc_next = 5'd1;
        end else if ((state == EMIT) && xfer) begin
            k_next  = key_update(k, rc);
            rc_next = rc + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= '0;
            rc       <= '0;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            k        <= k_next;
            rc       <= rc_next;
            busy     <= busy_next;
            rk_valid <= busy_next;
            done     <= done_next;
        end
    end

    // The counter wraps 31 -> 0 on the K31 transfer, so index 0 tags K32.
    assign round_key = k[79:16];
    assign rk_index  = rc;

endmodule

// File: tb/tb_present_key_schedule.sv
// tb/tb_present_key_schedule.sv - directed bench for present_key_schedule
module tb_present_key_schedule;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [79:0] key;
    logic        rk_ready;
    logic        busy;
    logic        rk_valid;
    logic [4:0]  rk_index;
    logic [63:0] round_key;
    logic        done;

    int n_tests;
    int n_fail;

    logic [63:0] expk [1:32];
    logic [63:0] rx   [1:32];

    localparam logic [63:0] SB = 64'h2174_8FE3_DA09_B65C;

    present_key_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
        .rk_ready  (rk_ready),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_index  (rk_index),
        .round_key (round_key),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] sb_lookup(input logic [3:0] x);
        return SB[int'(x) * 4 +: 4];
    endfunction

    function automatic logic [79:0] ks_step(input logic [79:0] kk, input logic [4:0] i);
        logic [79:0] r;
        r        = (kk << 61) | (kk >> 19);
        r[79:76] = sb_lookup(r[79:76]);
        r[19:15] = r[19:15] ^ i;
        return r;
    endfunction

    task automatic build_expected(input logic [79:0] kin);
        logic [79:0] kk;
        kk = kin;
        expk[1] = kk[79:16];
        for (int i = 1; i <= 31; i++) begin
            kk = ks_step(kk, 5'(i));
            expk[i+1] = kk[79:16];
        end
    endtask

    // Reference PRESENT encryption driven by the round keys received from the DUT.
    function automatic logic [63:0] present_enc(input logic [63:0] pt);
        logic [63:0] s;
        logic [63:0] t;
        s = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ rx[r];
            for (int n = 0; n < 16; n++) s[n*4 +: 4] = sb_lookup(s[n*4 +: 4]);
            t = '0;
            for (int b = 0; b < 63; b++) t[(b * 16) % 63] = s[b];
            t[63] = s[63];
            s = t;
        end
        return s ^ rx[32];
    endfunction

    task automatic run_keys(input logic [79:0] kin, input int stall_idx, input int stall_n,
                            input int stall_last_n, input int busy_start_idx,
                            input int abort_idx, input bit hold);
        int idx;
        int w;
        int wl;
        int cycles;
        bit aborted;
        build_expected(kin);
        idx = 1; w = 0; wl = 0; cycles = 0; aborted = 0;
        @(negedge clk);
        start = 1'b1;
        key   = kin;
        @(negedge clk);
        while (idx <= 32 && cycles < 200 && !aborted) begin
            check("valid", 80'(rk_valid), 80'd1);
            check("busy", 80'(busy), 80'd1);
            check($sformatf("rk_%0d", idx), 80'(round_key), 80'(expk[idx]));
            check("index", 80'(rk_index), 80'(idx % 32));
            check("done", 80'(done), 80'(idx == 32));
            start = hold || (idx == busy_start_idx);
            key   = (idx == busy_start_idx) ? 80'h0123_4567_89AB_CDEF_0F1E : (hold ? kin : ~kin);
            if (idx == abort_idx) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_valid", 80'(rk_valid), 80'd0);
                check("rst_busy", 80'(busy), 80'd0);
                check("rst_done", 80'(done), 80'd0);
                check("rst_key", 80'(round_key), 80'd0);
                check("rst_index", 80'(rk_index), 80'd0);
                start = 1'b0;
                @(negedge clk);
                rst_n   = 1'b1;
                aborted = 1;
            end else begin
                if (idx == stall_idx && w < stall_n) begin
                    rk_ready = 1'b0;
                    w++;
                end else if (idx == 32 && wl < stall_last_n) begin
                    rk_ready = 1'b0;
                    wl++;
                end else begin
                    rk_ready = 1'b1;
                    rx[idx]  = round_key;
                    idx++;
                end
                @(negedge clk);
                cycles++;
            end
        end
        rk_ready = 1'b1;
        if (!aborted) begin
            check("seq_len", 80'(idx), 80'd33);
            check("end_valid", 80'(rk_valid), 80'd0);
            check("end_busy", 80'(busy), 80'd0);
            check("end_done", 80'(done), 80'd0);
            if (hold) begin
                @(negedge clk);
                start = 1'b0;
                check("restart_valid", 80'(rk_valid), 80'd1);
                check("restart_k1", 80'(round_key), 80'(expk[1]));
                check("restart_index", 80'(rk_index), 80'd1);
                cycles = 0;
                while (busy && cycles < 100) begin
                    @(negedge clk);
                    cycles++;
                end
                check("drain_busy", 80'(busy), 80'd0);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        key      = '0;
        rk_ready = 1'b1;
        #12;
        check("reset_valid", 80'(rk_valid), 80'd0);
        check("reset_busy", 80'(busy), 80'd0);
        check("reset_key", 80'(round_key), 80'd0);
        check("reset_index", 80'(rk_index), 80'd0);
        check("reset_done", 80'(done), 80'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_keys(80'h0, 0, 0, 0, 0, 0, 1'b0);
        check("zero_k1", 80'(rx[1]), 80'h0000_0000_0000_0000);
        check("zero_k2", 80'(rx[2]), 80'hC000_0000_0000_0000);
        check("zero_k3", 80'(rx[3]), 80'h5000_1800_0000_0001);
        check("cipher_zero", 80'(present_enc(64'h0)), 80'h5579_C138_7B22_8445);

        run_keys(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 5, 3, 1, 0, 0, 1'b0);
        run_keys(80'hAABB_CCDD_AABB_CCDD_CCDD, 0, 0, 0, 10, 0, 1'b0);
        run_keys(80'hAABB_CCDD_AABB_CCDD_CCDD, 0, 0, 0, 0, 17, 1'b0);
        run_keys(80'h1357_9BDF_0246_8ACE_5A5A, 0, 0, 0, 0, 0, 1'b0);
        run_keys(80'h0, 0, 0, 0, 0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
